// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller:
// opcode/func values, state encodings, datapath select encodings and decode classes.
package mc_ctrl_pkg;

   localparam int unsigned OP_W  = 6;
   localparam int unsigned ST_W  = 3;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 32;

   // Primary opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
   localparam logic [OP_W-1:0] FN_JR   = 6'h08;
   localparam logic [OP_W-1:0] FN_JALR = 6'h09;
   localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB  = 6'h22;

   typedef enum logic [ST_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   // Next-PC source
   localparam logic [SEL_W-1:0] NPC_PC4  = 3'b000;
   localparam logic [SEL_W-1:0] NPC_BEQ  = 3'b001;
   localparam logic [SEL_W-1:0] NPC_JUMP = 3'b010;
   localparam logic [SEL_W-1:0] NPC_RS   = 3'b011;

   // Register-file write address source
   localparam logic [SEL_W-1:0] WRA3_RT = 3'b000;
   localparam logic [SEL_W-1:0] WRA3_RD = 3'b001;
   localparam logic [SEL_W-1:0] WRA3_RA = 3'b010;

   // Register-file write data source
   localparam logic [SEL_W-1:0] WD_ALU = 3'b000;
   localparam logic [SEL_W-1:0] WD_MDR = 3'b001;
   localparam logic [SEL_W-1:0] WD_PC  = 3'b010;

   // ALU operations
   localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [SEL_W-1:0] ALU_OR  = 3'b010;
   localparam logic [SEL_W-1:0] ALU_LUI = 3'b011;
   localparam logic [SEL_W-1:0] ALU_SLL = 3'b100;

   // One-hot instruction class; link qualifies jump/jreg, alu_op qualifies alu_r/alu_i
   typedef struct packed {
      logic              alu_r;
      logic              alu_i;
      logic              load;
      logic              store;
      logic              branch;
      logic              jump;
      logic              jreg;
      logic              illegal;
      logic              link;
      logic [SEL_W-1:0]  alu_op;
   } dec_t;

   // Instructions that finish in DECODE
   function automatic logic ends_in_decode(input dec_t d);
      return d.jump | d.jreg | d.illegal;
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational opcode/func classifier feeding the controller FSM.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   input  logic [OP_W-1:0] func,
   output dec_t            dec_c
);

   // func is only meaningful for R-type; every other opcode ignores it
   always_comb begin
      dec_c = '0;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (func)
               FN_ADD: begin
                  dec_c.alu_r  = 1'b1;
                  dec_c.alu_op = ALU_ADD;
               end
               FN_SUB: begin
                  dec_c.alu_r  = 1'b1;
                  dec_c.alu_op = ALU_SUB;
               end
               FN_SLL: begin
                  dec_c.alu_r  = 1'b1;
                  dec_c.alu_op = ALU_SLL;
               end
               FN_JR: begin
                  dec_c.jreg = 1'b1;
               end
               FN_JALR: begin
                  dec_c.jreg = 1'b1;
                  dec_c.link = 1'b1;
               end
               default: dec_c.illegal = 1'b1;
            endcase
         end
         OP_ORI: begin
            dec_c.alu_i  = 1'b1;
            dec_c.alu_op = ALU_OR;
         end
         OP_LUI: begin
            dec_c.alu_i  = 1'b1;
            dec_c.alu_op = ALU_LUI;
         end
         OP_LW:  dec_c.load   = 1'b1;
         OP_SW:  dec_c.store  = 1'b1;
         OP_BEQ: dec_c.branch = 1'b1;
         OP_J:   dec_c.jump   = 1'b1;
         OP_JAL: begin
            dec_c.jump = 1'b1;
            dec_c.link = 1'b1;
         end
         default: dec_c.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing of a shared datapath.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter logic [ST_W-1:0] RESET_STATE = 3'd0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  opcode,
   input  logic [OP_W-1:0]  func,
   input  logic             zero,
   output logic             PCWr,
   output logic             IRWr,
   output logic [SEL_W-1:0] NPCOp,
   output logic             RFWr,
   output logic [SEL_W-1:0] WRA3Sel,
   output logic [SEL_W-1:0] WDSel,
   output logic [SEL_W-1:0] ALUOp,
   output logic             BSel,
   output logic             EXTOp,
   output logic             DMWr,
   output logic             instr_done,
   output logic [ST_W-1:0]  state
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_e state_q, state_d;
   dec_t   dec;

   mc_ctrl_decode u_decode (
      .opcode (opcode),
      .func   (func),
      .dec_c  (dec)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= state_e'(RESET_STATE);
      else       state_q <= state_d;
   end

   assign state = ST_W'(state_q);

   // Next state and per-state datapath controls
   always_comb begin
      state_d    = ST_FETCH;
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      NPCOp      = NPC_PC4;
      RFWr       = 1'b0;
      WRA3Sel    = WRA3_RT;
      WDSel      = WD_ALU;
      ALUOp      = ALU_ADD;
      BSel       = 1'b0;
      EXTOp      = 1'b0;
      DMWr       = 1'b0;
      instr_done = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            NPCOp   = NPC_PC4;
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            if (dec.jump) begin
               PCWr  = 1'b1;
               NPCOp = NPC_JUMP;
               if (dec.link) begin
                  RFWr    = 1'b1;
                  WRA3Sel = WRA3_RA;
                  WDSel   = WD_PC;
               end
            end else if (dec.jreg) begin
               // PC takes rs from the A latch, so a jalr with rd==rs still jumps to the old value
               PCWr  = 1'b1;
               NPCOp = NPC_RS;
               if (dec.link) begin
                  RFWr    = 1'b1;
                  WRA3Sel = WRA3_RD;
                  WDSel   = WD_PC;
               end
            end
            if (ends_in_decode(dec)) begin
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end else begin
               state_d    = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (dec.alu_r) begin
               ALUOp   = dec.alu_op;
               BSel    = 1'b0;
               state_d = ST_WB;
            end else if (dec.alu_i) begin
               ALUOp   = dec.alu_op;
               BSel    = 1'b1;
               EXTOp   = 1'b0;
               state_d = ST_WB;
            end else if (dec.load || dec.store) begin
               ALUOp   = ALU_ADD;
               BSel    = 1'b1;
               EXTOp   = 1'b1;
               state_d = ST_MEM;
            end else if (dec.branch) begin
               ALUOp      = ALU_SUB;
               BSel       = 1'b0;
               PCWr       = zero;
               NPCOp      = NPC_BEQ;
               EXTOp      = 1'b1;
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_MEM: begin
            if (dec.store) begin
               DMWr       = 1'b1;
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end else if (dec.load) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_WB: begin
            RFWr       = 1'b1;
            instr_done = 1'b1;
            if (dec.alu_r) begin
               WRA3Sel = WRA3_RD;
               WDSel   = WD_ALU;
            end else if (dec.load) begin
               WRA3Sel = WRA3_RT;
               WDSel   = WD_MDR;
            end else begin
               WRA3Sel = WRA3_RT;
               WDSel   = WD_ALU;
            end
            state_d = ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase

      // A reset cycle abandons the instruction: no architectural write may happen
      if (reset) begin
         PCWr       = 1'b0;
         IRWr       = 1'b0;
         RFWr       = 1'b0;
         DMWr       = 1'b0;
         instr_done = 1'b0;
      end
   end

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      instr_cnt_d = instr_cnt_q + CNT_W'(instr_done);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed vector bench for mc_ctrl_fsm: per-cycle output table plus instruction latency checks.
module tb_mc_ctrl_fsm;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       PCWr, IRWr, RFWr, BSel, EXTOp, DMWr, instr_done;
   logic [2:0] NPCOp, WRA3Sel, WDSel, ALUOp, state;

   mc_ctrl_fsm dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .func       (func),
      .zero       (zero),
      .PCWr       (PCWr),
      .IRWr       (IRWr),
      .NPCOp      (NPCOp),
      .RFWr       (RFWr),
      .WRA3Sel    (WRA3Sel),
      .WDSel      (WDSel),
      .ALUOp      (ALUOp),
      .BSel       (BSel),
      .EXTOp      (EXTOp),
      .DMWr       (DMWr),
      .instr_done (instr_done),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pcwr;
      logic       irwr;
      logic [2:0] npc;
      logic       rfwr;
      logic [2:0] wra3;
      logic [2:0] wds;
      logic [2:0] alu;
      logic       bsel;
      logic       ext;
      logic       dmwr;
      logic       done;
   } outs_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       en_only;
      outs_t      exp;
   } vec_t;

   vec_t  vq[$];
   int    n_vec;
   int    n_miss;
   outs_t en_mask;

   function automatic outs_t mk(input logic [2:0] st, input logic pcwr, input logic irwr,
                                input logic [2:0] npc, input logic rfwr, input logic [2:0] wra3,
                                input logic [2:0] wds, input logic [2:0] alu, input logic bsel,
                                input logic ext, input logic dmwr, input logic done);
      outs_t o;
      o.st = st;   o.pcwr = pcwr; o.irwr = irwr; o.npc = npc;
      o.rfwr = rfwr; o.wra3 = wra3; o.wds = wds; o.alu = alu;
      o.bsel = bsel; o.ext = ext; o.dmwr = dmwr; o.done = done;
      return o;
   endfunction

   task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic eo, input outs_t e);
      vec_t v;
      v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.en_only = eo; v.exp = e;
      vq.push_back(v);
   endtask

   function automatic outs_t actual();
      return outs_t'({state, PCWr, IRWr, NPCOp, RFWr, WRA3Sel, WDSel, ALUOp,
                      BSel, EXTOp, DMWr, instr_done});
   endfunction

   // Runs one instruction from FETCH and checks cycles until instr_done
   task automatic latency(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int exp_cyc);
      int n;
      @(negedge clk);
      reset = 1'b0; opcode = op; func = fn; zero = z;
      #2;
      n = 1;
      while (!instr_done && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      n_vec++;
      if (!instr_done || n != exp_cyc) begin
         n_miss++;
         $display("FAIL latency %s: got %0d cycles (done=%0b), want %0d", name, n, instr_done, exp_cyc);
      end
   endtask

   outs_t F, D0, Z;

   initial begin
      reset = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0;
      n_vec = 0; n_miss = 0;
      en_mask = '0;
      en_mask.pcwr = 1'b1; en_mask.irwr = 1'b1; en_mask.rfwr = 1'b1;
      en_mask.dmwr = 1'b1; en_mask.done = 1'b1;

      //      st pc ir npc rf wra3 wds alu bs ex dm dn
      F  = mk(0, 1, 1, 0,  0, 0,   0,  0,  0, 0, 0, 0);
      D0 = mk(1, 0, 0, 0,  0, 0,   0,  0,  0, 0, 0, 0);
      Z  = '0;

      // reset held 3 cycles
      add(1, 6'h00, 6'h00, 0, 1, Z);
      add(1, 6'h00, 6'h00, 0, 1, Z);
      add(1, 6'h00, 6'h00, 0, 1, Z);
      // ori $1,$0,0x1234
      add(0, 6'h0D, 6'h34, 0, 0, F);
      add(0, 6'h0D, 6'h34, 0, 0, D0);
      add(0, 6'h0D, 6'h34, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
      add(0, 6'h0D, 6'h34, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      // lw
      add(0, 6'h23, 6'h04, 0, 0, F);
      add(0, 6'h23, 6'h04, 0, 0, D0);
      add(0, 6'h23, 6'h04, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      add(0, 6'h23, 6'h04, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(0, 6'h23, 6'h04, 0, 0, mk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
      // sw
      add(0, 6'h2B, 6'h08, 0, 0, F);
      add(0, 6'h2B, 6'h08, 0, 0, D0);
      add(0, 6'h2B, 6'h08, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      add(0, 6'h2B, 6'h08, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      // beq taken, then not taken
      add(0, 6'h04, 6'h01, 1, 0, F);
      add(0, 6'h04, 6'h01, 1, 0, D0);
      add(0, 6'h04, 6'h01, 1, 0, mk(2, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1));
      add(0, 6'h04, 6'h01, 0, 0, F);
      add(0, 6'h04, 6'h01, 0, 0, D0);
      add(0, 6'h04, 6'h01, 0, 0, mk(2, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1));
      // jal 0x0C000010
      add(0, 6'h03, 6'h10, 0, 0, F);
      add(0, 6'h03, 6'h10, 0, 0, mk(1, 1, 0, 2, 1, 2, 2, 0, 0, 0, 0, 1));
      // jalr rd=$31
      add(0, 6'h00, 6'h09, 0, 0, F);
      add(0, 6'h00, 6'h09, 0, 0, mk(1, 1, 0, 3, 1, 1, 2, 0, 0, 0, 0, 1));
      // j, jr
      add(0, 6'h02, 6'h00, 0, 0, F);
      add(0, 6'h02, 6'h00, 0, 0, mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1));
      add(0, 6'h00, 6'h08, 0, 0, F);
      add(0, 6'h00, 6'h08, 0, 0, mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1));
      // add, sub, sll, lui
      add(0, 6'h00, 6'h20, 0, 0, F);
      add(0, 6'h00, 6'h20, 0, 0, D0);
      add(0, 6'h00, 6'h20, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(0, 6'h00, 6'h20, 0, 0, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      add(0, 6'h00, 6'h22, 0, 0, F);
      add(0, 6'h00, 6'h22, 0, 0, D0);
      add(0, 6'h00, 6'h22, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      add(0, 6'h00, 6'h22, 0, 0, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      add(0, 6'h00, 6'h00, 0, 0, F);
      add(0, 6'h00, 6'h00, 0, 0, D0);
      add(0, 6'h00, 6'h00, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
      add(0, 6'h00, 6'h00, 0, 0, mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      add(0, 6'h0F, 6'h00, 0, 0, F);
      add(0, 6'h0F, 6'h00, 0, 0, D0);
      add(0, 6'h0F, 6'h00, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
      add(0, 6'h0F, 6'h00, 0, 0, mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      // reset in MEM of sw
      add(0, 6'h2B, 6'h00, 0, 0, F);
      add(0, 6'h2B, 6'h00, 0, 0, D0);
      add(0, 6'h2B, 6'h00, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      add(1, 6'h2B, 6'h00, 0, 1, Z);
      add(0, 6'h2B, 6'h00, 0, 0, F);
      // reset in WB of add
      add(0, 6'h00, 6'h20, 0, 0, D0);
      add(0, 6'h00, 6'h20, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(1, 6'h00, 6'h20, 0, 1, Z);
      add(0, 6'h00, 6'h20, 0, 0, F);
      // illegal opcode and illegal func: NOP ending in DECODE
      add(0, 6'h3F, 6'h00, 0, 0, D0 | mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      add(0, 6'h00, 6'h3F, 0, 0, F);
      add(0, 6'h00, 6'h3F, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      foreach (vq[i]) begin
         outs_t a, m;
         @(negedge clk);
         reset  = vq[i].rst;
         opcode = vq[i].op;
         func   = vq[i].fn;
         zero   = vq[i].z;
         #2;
         a = actual();
         m = vq[i].en_only ? en_mask : '1;
         n_vec++;
         if ((a & m) !== (vq[i].exp & m)) begin
            n_miss++;
            $display("FAIL vec %0d: got %06h, want %06h (mask %06h)", i, a, vq[i].exp, m);
         end
      end

      latency("lw",   6'h23, 6'h00, 0, 5);
      latency("sw",   6'h2B, 6'h00, 0, 4);
      latency("add",  6'h00, 6'h20, 0, 4);
      latency("ori",  6'h0D, 6'h00, 0, 4);
      latency("beq",  6'h04, 6'h00, 1, 3);
      latency("j",    6'h02, 6'h00, 0, 2);
      latency("jalr", 6'h00, 6'h09, 0, 2);
      latency("nop",  6'h3F, 6'h3F, 0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle main controller for the MIPS-subset datapath (add, sub, ori, lw, sw, beq, lui, sll, j, jal, jr, jalr).
- Sequences one shared ALU, register file and memory port through FETCH/DECODE/EXEC/MEM/WB states.
- Drives per-state write enables and mux selects from opcode/func and the ALU zero flag.
- Sits between the instruction register and the datapath muxes; replaces the single-cycle decoder.

Parameters:
RESET_STATE, 3'd0, state entered on reset (FETCH).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26], valid from DECODE onward
func  input  6  IR[5:0]
zero  input  1  ALU equality flag, valid in EXEC
PCWr  output  1  PC register write enable
IRWr  output  1  instruction register write enable
NPCOp  output  3  000 PC+4, 001 beq target, 010 j/jal target, 011 rs (jr/jalr)
RFWr  output  1  register-file write enable
WRA3Sel  output  3  000 rt, 001 rd, 010 $31
WDSel  output  3  000 ALU result, 001 MDR, 010 PC (already PC+4)
ALUOp  output  3  000 add, 001 sub, 010 or, 011 lui, 100 sll
BSel  output  1  0 register B, 1 extended immediate
EXTOp  output  1  0 zero-extend, 1 sign-extend
DMWr  output  1  data-memory write enable
instr_done  output  1  one-cycle pulse in an instruction's last cycle
state  output  3  current state, for debug

Behaviour:
- One clock, `clk`. Reset `reset` is synchronous and active-high.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. The state register is the only mandatory storage.
- Outputs are Moore/Mealy combinational from the state, opcode, func and zero. Unlisted outputs are 0 in every state.
- While reset is high, all enables (PCWr, IRWr, RFWr, DMWr, instr_done) are 0. The state loads FETCH on the next edge.
- Reset mid-instruction abandons the instruction. No partial write occurs after the reset edge.
- FETCH: IRWr=1, PCWr=1, NPCOp=000. Next state is DECODE.
- DECODE:
  - j: PCWr=1, NPCOp=010, instr_done=1. Next state is FETCH.
  - jal: as j, plus RFWr=1, WRA3Sel=010, WDSel=010.
  - jr: PCWr=1, NPCOp=011, instr_done=1. Next state is FETCH.
  - jalr: as jr, plus RFWr=1, WRA3Sel=001, WDSel=010. The PC uses the rs value latched before the write, so rd==rs is safe.
  - Unknown opcode/func: instr_done=1, next state is FETCH (treated as a NOP).
  - All other instructions: next state is EXEC.
- EXEC:
  - add/sub/sll: ALUOp per op, BSel=0. Next state is WB.
  - ori/lui: ALUOp 010/011, BSel=1, EXTOp=0. Next state is WB.
  - lw/sw: ALUOp=000, BSel=1, EXTOp=1. Next state is MEM.
  - beq: ALUOp=001, BSel=0, PCWr=zero, NPCOp=001, EXTOp=1, instr_done=1. Next state is FETCH.
- MEM:
  - sw: DMWr=1, instr_done=1. Next state is FETCH.
  - lw: MDR loads. Next state is WB.
- WB: RFWr=1, instr_done=1. Next state is FETCH.
  - R-type (add/sub/sll): WRA3Sel=001, WDSel=000.
  - ori/lui: WRA3Sel=000, WDSel=000.
  - lw: WRA3Sel=000, WDSel=001.
- Latency in cycles: jumps 2, beq 3, sw 4, ALU ops 4, lw 5.
- The state must never hold an encoding 5–7. If it does, the next state is FETCH and all enables are 0.

Optional Feature:
PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on instr_done.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - opcode/func constants;
  - state encodings;
  - NPCOp/WDSel/WRA3Sel/ALUOp encodings.
- One sub-module, mc_ctrl_decode: purely combinational opcode/func to one-hot instruction class (alu_r, alu_i, load, store, branch, jump, link, jreg, illegal). The FSM consumes these one-hot lines.

Test Plan:
- Reset held 3 cycles, then released → state=0, and FETCH outputs appear with PCWr=1, IRWr=1 in the first cycle after release.
- ori $1,$0,0x1234 (0x34011234) → states 0,1,2,4; WB has RFWr=1, WRA3Sel=000, ALUOp=010 in EXEC; instr_done only in the WB cycle.
- lw then sw → lw visits 0,1,2,3,4 with WDSel=001 in WB; sw visits 0,1,2,3 with DMWr=1 only in MEM; EXTOp=1 in EXEC for both.
- beq with zero=1, then zero=0 → PCWr=1/NPCOp=001 in EXEC, then PCWr=0; both return to FETCH after 3 cycles.
- jal (0x0C000010) and jalr rd=$31 → 2-cycle instructions; DECODE shows PCWr=1, RFWr=1, WDSel=010, with WRA3Sel=010 and 001 respectively.
- Reset asserted in MEM of sw and in WB of an add → DMWr/RFWr are 0 in the reset cycle and the next state is FETCH; opcode 0x3F → NOP returning to FETCH after DECODE.
